prog_clk_div: RTL and testbench
===============================

# prog_clk_div

Multi-channel programmable clock divider. Each channel runs an independent down-counter from its own runtime-loadable divisor. On each terminal count a channel either toggles its output (50 % square wave, period 2·N clocks) or emits a one-cycle pulse (period N clocks). It sits beside the system clock and supplies slow enables and strobes (LED blink, scan, baud ticks) to downstream logic in the same clock domain.

## Interface
- WIDTH, 8: counter and divisor width in bits.
- CHANNELS, 2: number of independent divider channels.
- DEFAULT_DIV, 50: divisor and counter value loaded at reset; must be 1..2^WIDTH-1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  CHANNELS  per-channel count enable.
- mode  in  CHANNELS  per-channel output mode: 0 = toggle, 1 = pulse.
- restart  in  1  synchronous restart of all channels: cnt ← div, f_out ← 0.
- load  in  1  one-cycle strobe that writes load_val into the divisor of channel load_ch.
- load_ch  in  $clog2(CHANNELS) (min 1)  target channel for load.
- load_val  in  WIDTH  new divisor, valid range 1..2^WIDTH-1.
- f_out  out  CHANNELS  divided output per channel, registered.
- tick  out  CHANNELS  one-cycle terminal-count strobe per channel, registered.
- load_err  out  1  one-cycle strobe when a load is rejected.
- cnt_out  out  CHANNELS·WIDTH  current counters, channel i at bits [i·WIDTH +: WIDTH].

## Operation
- Per-channel state: div[i], cnt[i], f_out[i], tick[i].
- Reset (rst=0): div = cnt = DEFAULT_DIV, f_out = 0, tick = 0, load_err = 0, for all channels.
- Priority per edge is: restart, then count. load is evaluated independently.
- restart=1: every cnt[i] ← div[i], f_out ← 0, tick ← 0, regardless of en.
- en[i]=1 and cnt[i] > 1: cnt[i] ← cnt[i] − 1, tick[i] ← 0.
- en[i]=1 and cnt[i] == 1 (terminal count):
  - cnt[i] ← div[i] (the value before any same-edge load);
  - tick[i] ← 1;
  - mode 0: f_out[i] ← ~f_out[i];
  - mode 1: f_out[i] ← 1.
- Outside terminal count, mode 1 forces f_out[i] ← 0. Mode 0 holds f_out.
- en[i]=0: cnt and mode-0 f_out hold, tick ← 0. Mode-1 f_out ← 0.
- load=1 with load_val ≠ 0 and load_ch < CHANNELS: div[load_ch] ← load_val. cnt is not touched, so the new divisor takes effect at the next reload. This keeps the output glitch-free.
- load=1 with load_val == 0 or load_ch ≥ CHANNELS: div is unchanged and load_err ← 1 for one cycle.
- A mode change takes effect at the next edge. Switching to mode 1 drives f_out low until the next terminal count.
- The counter never reaches 0 and never wraps. div == 1 means terminal count on every enabled edge.

## Timing
- After reset release with en held high, the first tick is registered on the DEFAULT_DIV-th rising edge. It is visible for exactly one cycle.
- Steady state with divisor N:
  - tick period N clocks;
  - mode-0 f_out period 2N clocks, high N / low N;
  - mode-1 f_out identical to tick.
- Load latency: div updates 1 edge after the load strobe. The output period changes after the in-flight count finishes.
- restart latency: 1 edge. The first tick after restart comes N enabled edges later.
- load_err is asserted on the edge after the bad load and deasserted 1 edge later unless the bad load repeats.
- Asynchronous reset mid-count: all outputs clear immediately. No partial period completes.

## Test plan
- Reset with DEFAULT_DIV=50, en=1, mode=0 → tick at edges 50, 100, …; f_out rises at edge 50 and falls at edge 100.
- Load ch1 with 3, mode 1, while ch0 runs at 50 → ch1 ticks every 3 clocks after finishing its current count; ch0 is unaffected.
- Load with load_val=0 → load_err high for 1 cycle, div unchanged, period still 50.
- Load a new value on the same edge as terminal count → reload uses the old div; the next period uses the new value.
- Drop en for 10 cycles mid-count → cnt_out frozen, tick low; the period resumes with 10 cycles of added delay.
- Assert restart mid-count → cnt = div, f_out = 0 after 1 edge. Assert rst low mid-count → all outputs 0 asynchronously. div=1 in mode 0 → f_out toggles every clock.

Source files
------------

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider: per-channel down-counters with
// runtime-loadable divisors, producing toggle (square wave) or pulse outputs.
module prog_clk_div #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int DEFAULT_DIV = 50,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic                      restart,
  input  logic                      load,
  input  logic [CH_W-1:0]           load_ch,
  input  logic [WIDTH-1:0]          load_val,
  output logic [CHANNELS-1:0]       f_out,
  output logic [CHANNELS-1:0]       tick,
  output logic                      load_err,
  output logic [CHANNELS*WIDTH-1:0] cnt_out
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] div [CHANNELS];
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic             load_ok;

  // A zero divisor would stall the counter; out-of-range channels have no storage.
  assign load_ok = (load_val != '0) && (int'(load_ch) < CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt_out
    assign cnt_out[g*WIDTH +: WIDTH] = cnt[g];
  end

  // NOTE: all state here is updated with non-blocking assignments, so a
  // terminal-count reload reads the divisor value from before any same-edge load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the divisor array is reset too, because the counters reload from it
      // and must start from DEFAULT_DIV rather than from an unknown value.
      for (int i = 0; i < CHANNELS; i++) begin
        div[i] <= DEF_DIV;
        cnt[i] <= DEF_DIV;
      end
      f_out    <= '0;
      tick     <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load && !load_ok;
      if (load && load_ok) begin
        div[load_ch] <= load_val;
      end

      for (int i = 0; i < CHANNELS; i++) begin
        if (restart) begin
          cnt[i]   <= div[i];
          f_out[i] <= 1'b0;
          tick[i]  <= 1'b0;
        end else if (en[i]) begin
          if (cnt[i] == ONE) begin
            cnt[i]   <= div[i];
            tick[i]  <= 1'b1;
            f_out[i] <= mode[i] ? 1'b1 : ~f_out[i];
          end else begin
            cnt[i]  <= cnt[i] - ONE;
            tick[i] <= 1'b0;
            if (mode[i]) f_out[i] <= 1'b0;
          end
        end else begin
          // Paused: count and square wave hold, pulse output stays low.
          tick[i] <= 1'b0;
          if (mode[i]) f_out[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: linear stimulus with hand-computed
// expected values, checked by immediate assertions.
module tb_prog_clk_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [1:0]  mode;
  logic        restart;
  logic        load;
  logic [0:0]  load_ch;
  logic [7:0]  load_val;
  logic [1:0]  f_out;
  logic [1:0]  tick;
  logic        load_err;
  logic [15:0] cnt_out;

  int vectors     = 0;
  int miscompares = 0;

  prog_clk_div #(.WIDTH(8), .CHANNELS(2), .DEFAULT_DIV(50)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .restart  (restart),
    .load     (load),
    .load_ch  (load_ch),
    .load_val (load_val),
    .f_out    (f_out),
    .tick     (tick),
    .load_err (load_err),
    .cnt_out  (cnt_out)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // NOTE: inputs are driven with blocking assignments just after a rising
    // edge, so the DUT sees them stable at the following edge.
    rst = 1'b0; en = 2'b00; mode = 2'b00; restart = 1'b0;
    load = 1'b0; load_ch = 1'b0; load_val = 8'd0;

    edges(2);
    check("rst_cnt0",  32'(cnt_out[7:0]),  32'd50);
    check("rst_cnt1",  32'(cnt_out[15:8]), 32'd50);
    check("rst_f_out", 32'(f_out),         32'd0);
    check("rst_tick",  32'(tick),          32'd0);
    check("rst_err",   32'(load_err),      32'd0);

    // Release reset with both channels enabled in toggle mode.
    rst = 1'b1; en = 2'b11;
    edges(49);
    check("e49_cnt0",  32'(cnt_out[7:0]), 32'd1);
    check("e49_tick",  32'(tick),         32'd0);
    edges(1);
    check("e50_tick",  32'(tick),         32'd3);
    check("e50_f_out", 32'(f_out),        32'd3);
    check("e50_cnt0",  32'(cnt_out[7:0]), 32'd50);
    edges(1);
    check("e51_tick",  32'(tick),         32'd0);
    check("e51_f_out", 32'(f_out),        32'd3);
    edges(49);
    check("e100_tick", 32'(tick),         32'd3);
    check("e100_f_out",32'(f_out),        32'd0);

    // Load ch1 with 3 and switch it to pulse mode.
    load = 1'b1; load_ch = 1'b1; load_val = 8'd3; mode = 2'b10;
    edges(1);
    load = 1'b0;
    check("e101_cnt1", 32'(cnt_out[15:8]), 32'd49);
    check("e101_f_out",32'(f_out),         32'd0);
    edges(49);
    check("e150_tick", 32'(tick),          32'd3);
    check("e150_f_out",32'(f_out),         32'd3);
    check("e150_cnt1", 32'(cnt_out[15:8]), 32'd3);
    edges(1);
    check("e151_tick", 32'(tick),          32'd0);
    check("e151_f_out",32'(f_out),         32'd1);
    edges(2);
    check("e153_tick", 32'(tick),          32'd2);
    check("e153_f_out",32'(f_out),         32'd3);
    edges(3);
    check("e156_tick", 32'(tick),          32'd2);
    check("e156_cnt0", 32'(cnt_out[7:0]),  32'd44);

    // Rejected load of zero into ch0.
    load = 1'b1; load_ch = 1'b0; load_val = 8'd0;
    edges(1);
    load = 1'b0;
    check("bad_err_hi",32'(load_err),      32'd1);
    edges(1);
    check("bad_err_lo",32'(load_err),      32'd0);
    check("e158_cnt0", 32'(cnt_out[7:0]),  32'd42);
    edges(42);
    check("e200_tick", 32'(tick),          32'd1);
    check("e200_f_out0",32'(f_out[0]),     32'd0);
    check("e200_cnt0", 32'(cnt_out[7:0]),  32'd50);

    // Load on the same edge as the ch0 terminal count.
    edges(49);
    check("e249_cnt0", 32'(cnt_out[7:0]),  32'd1);
    load = 1'b1; load_ch = 1'b0; load_val = 8'd10;
    edges(1);
    load = 1'b0;
    check("e250_tick0",32'(tick[0]),       32'd1);
    check("e250_cnt0", 32'(cnt_out[7:0]),  32'd50);
    edges(50);
    check("e300_tick0",32'(tick[0]),       32'd1);
    check("e300_cnt0", 32'(cnt_out[7:0]),  32'd10);
    check("e300_f_out0",32'(f_out[0]),     32'd0);
    edges(10);
    check("e310_tick0",32'(tick[0]),       32'd1);
    check("e310_f_out0",32'(f_out[0]),     32'd1);

    // Pause ch0 for 10 cycles mid-count.
    edges(3);
    check("e313_cnt0", 32'(cnt_out[7:0]),  32'd7);
    en = 2'b10;
    edges(10);
    check("pause_cnt0",32'(cnt_out[7:0]),  32'd7);
    check("pause_tick0",32'(tick[0]),      32'd0);
    check("pause_f_out0",32'(f_out[0]),    32'd1);
    en = 2'b11;
    edges(6);
    check("e329_tick0",32'(tick[0]),       32'd0);
    edges(1);
    check("e330_tick0",32'(tick[0]),       32'd1);
    check("e330_f_out0",32'(f_out[0]),     32'd0);

    // Restart mid-count.
    edges(4);
    check("e334_cnt0", 32'(cnt_out[7:0]),  32'd6);
    restart = 1'b1;
    edges(1);
    restart = 1'b0;
    check("rs_cnt0",   32'(cnt_out[7:0]),  32'd10);
    check("rs_cnt1",   32'(cnt_out[15:8]), 32'd3);
    check("rs_f_out",  32'(f_out),         32'd0);
    check("rs_tick",   32'(tick),          32'd0);
    edges(9);
    check("rs9_tick0", 32'(tick[0]),       32'd0);
    edges(1);
    check("rs10_tick", 32'(tick),          32'd1);
    check("rs10_f_out0",32'(f_out[0]),     32'd1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b0;
    #1;
    check("arst_f_out",32'(f_out),         32'd0);
    check("arst_tick", 32'(tick),          32'd0);
    check("arst_cnt0", 32'(cnt_out[7:0]),  32'd50);
    edges(1);
    rst = 1'b1;

    // Divisor 1 in toggle mode: f_out0 toggles on every edge.
    mode = 2'b00;
    load = 1'b1; load_ch = 1'b0; load_val = 8'd1;
    edges(1);
    load = 1'b0; restart = 1'b1;
    edges(1);
    restart = 1'b0;
    check("d1_cnt0",   32'(cnt_out[7:0]),  32'd1);
    check("d1_f_out0", 32'(f_out[0]),      32'd0);
    edges(1);
    check("d1_a_f0",   32'(f_out[0]),      32'd1);
    check("d1_a_t0",   32'(tick[0]),       32'd1);
    check("d1_a_cnt0", 32'(cnt_out[7:0]),  32'd1);
    edges(1);
    check("d1_b_f0",   32'(f_out[0]),      32'd0);
    check("d1_b_t0",   32'(tick[0]),       32'd1);
    edges(1);
    check("d1_c_f0",   32'(f_out[0]),      32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
